stream_demux_rr: RTL and testbench

//   Round-robin stream demultiplexer: the distributing counterpart of the 2:1 mux

---
 rtl/stream_demux_rr_if.sv | 23 ++
 rtl/stream_demux_rr.sv | 72 +++++++
 tb/tb_stream_demux_rr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_rr_if.sv
// Handshake bundle for the round-robin demux: one input stream in, N_OUT
// registered output channels out. master = producer/consumer side, slave = demux.
interface stream_demux_rr_if #(
  parameter int N_OUT = 4,
  parameter int W     = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_data;
  logic [N_OUT-1:0]   out_valid;
  logic [N_OUT-1:0]   out_ready;
  logic [N_OUT*W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux_rr.sv
// Round-robin stream demultiplexer: deals accepted input words in strict
// rotation into N_OUT one-deep output registers, each with its own handshake.
module stream_demux_rr #(
  parameter  int N_OUT = 4,
  parameter  int W     = 8,
  localparam int PTR_W = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_demux_rr_if.slave  bus,
  output logic [PTR_W-1:0]  ptr,
  output logic [15:0]       acc_cnt
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_OUT - 1);

  logic [N_OUT-1:0] vld_p0;
  logic [W-1:0]     data_p0 [N_OUT];
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] drain;
  logic [PTR_W-1:0] ptr_nxt;
  logic             accept;

  // Only the channel under the pointer gates the input; a full slot that is
  // draining this cycle can be reloaded, so throughput never bubbles.
  assign bus.in_ready = ~vld_p0[ptr] | bus.out_ready[ptr];
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = vld_p0 & bus.out_ready;
  assign ptr_nxt      = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

  always_comb begin
    load = '0;
    for (int i = 0; i < N_OUT; i++) begin
      load[i] = accept && (ptr == PTR_W'(i));
    end
  end

  // ---- stage p0: per-channel output registers, pointer and accept counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= '0;
      ptr     <= '0;
      acc_cnt <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        data_p0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (load[i]) begin
          vld_p0[i]  <= 1'b1;
          data_p0[i] <= bus.in_data;
        end else if (drain[i]) begin
          vld_p0[i]  <= 1'b0;
        end
      end
      if (accept) begin
        ptr     <= ptr_nxt;
        acc_cnt <= acc_cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid = vld_p0;

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      bus.out_data[i*W +: W] = data_p0[i];
    end
  end

endmodule

// File: tb/tb_stream_demux_rr.sv
// Scoreboard bench for stream_demux_rr: a 4-channel and a 3-channel instance,
// directed stimulus with hand-assigned destination channels.
module tb_stream_demux_rr;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ptr4;
  logic [15:0] acc4;
  logic [1:0]  ptr3;
  logic [15:0] acc3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q4 [4][$];
  logic [7:0] q3 [3][$];

  stream_demux_rr_if #(.N_OUT(4), .W(8)) bus4 ();
  stream_demux_rr_if #(.N_OUT(3), .W(8)) bus3 ();

  stream_demux_rr #(.N_OUT(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .ptr(ptr4), .acc_cnt(acc4)
  );
  stream_demux_rr #(.N_OUT(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .ptr(ptr3), .acc_cnt(acc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) q4[i].delete();
    for (int i = 0; i < 3; i++) q3[i].delete();
  endtask

  // Offer a word to the 4-channel DUT; it must land on channel ch within max_wait stalls.
  task automatic send4(input logic [7:0] d, input int ch, input int max_wait);
    int waited = 0;
    bit ok = 1'b0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    while (!ok && waited <= max_wait) begin
      @(negedge clk);
      if (bus4.in_ready) begin
        ok = 1'b1;
        check("ptr4_at_accept", 32'(ptr4), 32'(ch));
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (ok) q4[ch].push_back(d);
    else    check("send4_timeout", 32'd0, 32'd1);
  endtask

  task automatic send3(input logic [7:0] d, input int ch, input int max_wait);
    int waited = 0;
    bit ok = 1'b0;
    bus3.in_valid = 1'b1;
    bus3.in_data  = d;
    while (!ok && waited <= max_wait) begin
      @(negedge clk);
      if (bus3.in_ready) begin
        ok = 1'b1;
        check("ptr3_at_accept", 32'(ptr3), 32'(ch));
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (ok) q3[ch].push_back(d);
    else    check("send3_timeout", 32'd0, 32'd1);
  endtask

  // Monitors: every held word must match the queue head; handshakes pop it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ch4_%0d_valid", i), 32'(bus4.out_valid[i]), 32'(q4[i].size() != 0));
        if (bus4.out_valid[i] && q4[i].size() != 0) begin
          check($sformatf("ch4_%0d_data", i), 32'(bus4.out_data[i*8 +: 8]), 32'(q4[i][0]));
          if (bus4.out_ready[i]) void'(q4[i].pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ch3_%0d_valid", i), 32'(bus3.out_valid[i]), 32'(q3[i].size() != 0));
        if (bus3.out_valid[i] && q3[i].size() != 0) begin
          check($sformatf("ch3_%0d_data", i), 32'(bus3.out_data[i*8 +: 8]), 32'(q3[i][0]));
          if (bus3.out_ready[i]) void'(q3[i].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = '0;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.out_ready = '0;
    clear_queues();
    #2;
    check("rst_out_valid4", 32'(bus4.out_valid), 32'h0);
    check("rst_out_data4",  32'(bus4.out_data),  32'h0);
    check("rst_ptr4",       32'(ptr4),           32'h0);
    check("rst_acc4",       32'(acc4),           32'h0);
    check("rst_out_valid3", 32'(bus3.out_valid), 32'h0);
    check("rst_ptr3",       32'(ptr3),           32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: continuous stream A0..A7, all consumers ready
    bus4.out_ready = 4'hF;
    for (int k = 0; k < 8; k++) send4(8'hA0 + 8'(k), k % 4, 0);
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_acc_cnt",   32'(acc4),           32'd8);
    check("t1_ptr",       32'(ptr4),           32'd0);
    check("t1_out_valid", 32'(bus4.out_valid), 32'h0);

    // Test 4: three-channel rotation, words 1..7
    @(posedge clk); #1;
    bus3.out_ready = 3'b111;
    for (int k = 0; k < 7; k++) send3(8'(k + 1), k % 3, 0);
    bus3.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t4_ptr3",       32'(ptr3),           32'd1);
    check("t4_acc3",       32'(acc3),           32'd7);
    check("t4_out_valid3", 32'(bus3.out_valid), 32'h0);

    // Test 2: consumers stalled, fill all four slots then stall on ch0
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_queues();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus4.out_ready = 4'h0;
    for (int k = 0; k < 4; k++) send4(8'hB0 + 8'(k), k, 0);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 8'hB4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t2_in_ready",  32'(bus4.in_ready),  32'd0);
      check("t2_ptr",       32'(ptr4),           32'd0);
      check("t2_acc_cnt",   32'(acc4),           32'd4);
      check("t2_out_valid", 32'(bus4.out_valid), 32'hF);
    end
    @(posedge clk); #1;

    // Test 3: drain and reload ch0 in the same cycle
    bus4.out_ready = 4'b0001;
    send4(8'h55, 0, 0);
    bus4.out_ready = 4'h0;
    bus4.in_valid  = 1'b0;
    @(negedge clk);
    check("t3_out_valid", 32'(bus4.out_valid),     32'hF);
    check("t3_ch0_data",  32'(bus4.out_data[7:0]), 32'h55);
    check("t3_ptr",       32'(ptr4),               32'd1);
    check("t3_acc_cnt",   32'(acc4),               32'd5);

    // Test 5: ch1 held full while the other channels drain
    @(posedge clk); #1;
    bus4.out_ready = 4'b1101;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 8'hC9;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_ch1_data",  32'(bus4.out_data[15:8]), 32'hB1);
      check("t5_ch1_valid", 32'(bus4.out_valid[1]),   32'd1);
      check("t5_in_ready",  32'(bus4.in_ready),       32'd0);
      check("t5_ptr",       32'(ptr4),                32'd1);
      if (c >= 1) check("t5_out_valid", 32'(bus4.out_valid), 32'b0010);
    end
    @(posedge clk); #1;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_drained", 32'(bus4.out_valid), 32'h0);

    // Test 6: asynchronous reset between edges, mid-burst
    @(posedge clk); #1;
    bus4.out_ready = 4'h0;
    send4(8'hC0, 1, 0);
    send4(8'hC1, 2, 0);
    #3;
    rst_n = 1'b0;
    clear_queues();
    #1;
    check("t6_out_valid", 32'(bus4.out_valid), 32'h0);
    check("t6_out_data",  32'(bus4.out_data),  32'h0);
    check("t6_ptr",       32'(ptr4),           32'd0);
    check("t6_acc_cnt",   32'(acc4),           32'd0);
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus4.out_ready = 4'hF;
    send4(8'hD0, 0, 0);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    check("t6_ptr_after", 32'(ptr4), 32'd1);
    check("t6_acc_after", 32'(acc4), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_drained", 32'(bus4.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
